// File: rtl/deframer_pkg.sv
// Shared types and default constants for the serial deframer.
package deframer_pkg;

    // Receiver states: searching for the sync header, or shifting in payload.
    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int unsigned DefaultWidth = 8;
    localparam logic [2:0]  DefaultSync  = 3'b110;

endpackage

// File: rtl/deframer_fifo.sv
// Two-entry output buffer for assembled frames; head visible without bypass.
module deframer_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    // When full, a same-edge pop frees the slot the write lands in.
    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    // Drive zero when empty so stale entries never leak out.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: hunts for a 3-bit sync header, collects WIDTH payload bits
// MSB first, and buffers completed frames in a two-entry FIFO.
module serial_deframer
    import deframer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter logic [2:0]  SYNC  = DefaultSync
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             BitIn,
    input  logic             BitValid,
    output logic [WIDTH-1:0] Data,
    output logic             DataValid,
    input  logic             DataReady,
    output logic             Busy,
    output logic             Overflow
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [2:0]       window_q, window_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] payload_q, payload_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Next-state: sync hunt and payload collection, frozen while BitValid is low.
    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        push      = 1'b0;
        push_data = {payload_q[WIDTH-2:0], BitIn};
        if (BitValid) begin
            case (state_q)
                HUNT: begin
                    if ({window_q[1:0], BitIn} == SYNC) begin
                        state_d  = COLLECT;
                        cnt_d    = '0;
                        window_d = 3'b000;
                    end else begin
                        window_d = {window_q[1:0], BitIn};
                    end
                end
                COLLECT: begin
                    payload_d = {payload_q[WIDTH-2:0], BitIn};
                    cnt_d     = cnt_q + CntW'(1);
                    // Final payload bit: hand the word to the buffer and resume hunting.
                    if (cnt_q == LastCnt) begin
                        push    = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
        overflow_d = push && fifo_full && !pop;
    end

    // State register; reset wins over everything on the same edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= HUNT;
            window_q   <= 3'b000;
            cnt_q      <= '0;
            payload_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            cnt_q      <= cnt_d;
            payload_q  <= payload_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop = DataValid && DataReady;

    deframer_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .Clock       (Clock),
        .Reset       (Reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (Data)
    );

    assign DataValid = !fifo_empty;
    assign Busy      = (state_q == COLLECT);
    assign Overflow  = overflow_q;

endmodule
